// File: rtl/can_bit_timing.sv
// CAN receive bit timing: tq prescaler, SYNC/TSEG1/TSEG2 sequencer, hard sync and SJW-limited resync.
// rx reaches the edge detector 2 clocks late; all strobes are registered and one clock wide, no backpressure.
module can_bit_timing (
  input  logic       clk100Mhz,
  input  logic       reset,
  input  logic [7:0] brp,
  input  logic [3:0] tseg1,
  input  logic [2:0] tseg2,
  input  logic [1:0] sjw,
  input  logic       hard_sync_en,
  input  logic       rx,
  input  logic       tx_bit,
  output logic       can_tx,
  output logic       sample_pulse,
  output logic       sampled_bit,
  output logic       tx_point,
  output logic       resync_event
);
  typedef enum logic [1:0] {ST_SYNC, ST_TSEG1, ST_TSEG2} state_t;

  state_t     state_q, state_d;
  logic [7:0] presc_q, presc_d;
  logic [4:0] seg_cnt_q, seg_cnt_d;
  logic [4:0] t1_lim_q, t1_lim_d;
  logic [4:0] t2_lim_q, t2_lim_d;
  logic       resync_done_q, resync_done_d;
  logic       rx_meta_q, rx_meta_d;
  logic       rx_s_q, rx_s_d;
  logic       rx_prev_q, rx_prev_d;
  logic       can_tx_q, can_tx_d;
  logic       sample_pulse_q, sample_pulse_d;
  logic       sampled_bit_q, sampled_bit_d;
  logic       tx_point_q, tx_point_d;
  logic       resync_event_q, resync_event_d;

  logic       tq_tick, rx_fall, hard_sync, resync_ok, end_early;
  logic [4:0] t1_cfg, t2_cfg, sjw_tq, t1_err, t1_jump, t2_err, t1_eff, t2_eff;

  assign can_tx       = can_tx_q;
  assign sample_pulse = sample_pulse_q;
  assign sampled_bit  = sampled_bit_q;
  assign tx_point     = tx_point_q;
  assign resync_event = resync_event_q;

  always_comb begin
    rx_meta_d      = rx;
    rx_s_d         = rx_meta_q;
    rx_prev_d      = rx_s_q;
    state_d        = state_q;
    seg_cnt_d      = seg_cnt_q;
    t1_lim_d       = t1_lim_q;
    t2_lim_d       = t2_lim_q;
    resync_done_d  = resync_done_q;
    can_tx_d       = can_tx_q;
    sampled_bit_d  = sampled_bit_q;
    sample_pulse_d = 1'b0;
    tx_point_d     = 1'b0;
    resync_event_d = 1'b0;
    end_early      = 1'b0;

    tq_tick   = (presc_q == brp);
    presc_d   = tq_tick ? 8'd0 : presc_q + 8'd1;
    rx_fall   = rx_prev_q & ~rx_s_q;
    hard_sync = hard_sync_en & rx_fall;
    resync_ok = rx_fall & ~hard_sync_en & ~resync_done_q & sampled_bit_q;

    t1_cfg  = (tseg1 == 4'd0) ? 5'd1 : {1'b0, tseg1};
    t2_cfg  = (tseg2 == 3'd0) ? 5'd1 : {2'b0, tseg2};
    sjw_tq  = {3'b0, sjw} + 5'd1;
    t1_err  = seg_cnt_q + 5'd1;
    t1_jump = (t1_err < sjw_tq) ? t1_err : sjw_tq;
    t2_err  = t2_lim_q - seg_cnt_q;
    t1_eff  = t1_lim_q;
    t2_eff  = t2_lim_q;

    if (hard_sync) begin
      state_d        = ST_SYNC;
      presc_d        = 8'd0;
      seg_cnt_d      = 5'd0;
      resync_done_d  = 1'b1;
      resync_event_d = 1'b1;
    end else begin
      // The adjusted limit is used in this same cycle so a tick that coincides with the edge sees it.
      if (resync_ok && state_q == ST_TSEG1) begin
        t1_eff         = t1_lim_q + t1_jump;
        t1_lim_d       = t1_eff;
        resync_done_d  = 1'b1;
        resync_event_d = 1'b1;
      end
      if (resync_ok && state_q == ST_TSEG2) begin
        if (t2_err <= sjw_tq) begin
          end_early = 1'b1;
        end else begin
          t2_eff   = t2_lim_q - sjw_tq;
          t2_lim_d = t2_eff;
        end
        resync_done_d  = 1'b1;
        resync_event_d = 1'b1;
      end

      if (end_early) begin
        state_d    = ST_SYNC;
        presc_d    = 8'd0;
        seg_cnt_d  = 5'd0;
        tx_point_d = 1'b1;
        can_tx_d   = tx_bit;
      end else if (tq_tick) begin
        case (state_q)
          ST_SYNC: begin
            state_d   = ST_TSEG1;
            seg_cnt_d = 5'd0;
            t1_lim_d  = t1_cfg;
          end
          ST_TSEG1: begin
            if (seg_cnt_q == t1_eff - 5'd1) begin
              state_d        = ST_TSEG2;
              seg_cnt_d      = 5'd0;
              t2_lim_d       = t2_cfg;
              sample_pulse_d = 1'b1;
              sampled_bit_d  = rx_s_q;
            end else begin
              seg_cnt_d = seg_cnt_q + 5'd1;
            end
          end
          ST_TSEG2: begin
            if (seg_cnt_q == t2_eff - 5'd1) begin
              state_d       = ST_SYNC;
              seg_cnt_d     = 5'd0;
              tx_point_d    = 1'b1;
              can_tx_d      = tx_bit;
              resync_done_d = 1'b0;
            end else begin
              seg_cnt_d = seg_cnt_q + 5'd1;
            end
          end
          default: begin
            state_d   = ST_SYNC;
            seg_cnt_d = 5'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk100Mhz) begin
    if (reset) begin
      state_q        <= ST_SYNC;
      presc_q        <= 8'd0;
      seg_cnt_q      <= 5'd0;
      t1_lim_q       <= 5'd1;
      t2_lim_q       <= 5'd1;
      resync_done_q  <= 1'b0;
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
      rx_prev_q      <= 1'b1;
      can_tx_q       <= 1'b1;
      sample_pulse_q <= 1'b0;
      sampled_bit_q  <= 1'b1;
      tx_point_q     <= 1'b0;
      resync_event_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      seg_cnt_q      <= seg_cnt_d;
      t1_lim_q       <= t1_lim_d;
      t2_lim_q       <= t2_lim_d;
      resync_done_q  <= resync_done_d;
      rx_meta_q      <= rx_meta_d;
      rx_s_q         <= rx_s_d;
      rx_prev_q      <= rx_prev_d;
      can_tx_q       <= can_tx_d;
      sample_pulse_q <= sample_pulse_d;
      sampled_bit_q  <= sampled_bit_d;
      tx_point_q     <= tx_point_d;
      resync_event_q <= resync_event_d;
    end
  end
endmodule

// File: tb/tb_can_bit_timing.sv
// Bench for can_bit_timing: directed vector table, a reset-mid-bit sequence and randomised runs
// checked every cycle against a position-in-bit reference model.
module tb_can_bit_timing;
  logic       clk100Mhz = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] brp = 8'd1;
  logic [3:0] tseg1 = 4'd5;
  logic [2:0] tseg2 = 3'd2;
  logic [1:0] sjw = 2'd0;
  logic       hard_sync_en = 1'b0;
  logic       rx = 1'b1;
  logic       tx_bit = 1'b1;
  logic       can_tx, sample_pulse, sampled_bit, tx_point, resync_event;

  can_bit_timing dut (
    .clk100Mhz(clk100Mhz), .reset(reset), .brp(brp), .tseg1(tseg1), .tseg2(tseg2),
    .sjw(sjw), .hard_sync_en(hard_sync_en), .rx(rx), .tx_bit(tx_bit),
    .can_tx(can_tx), .sample_pulse(sample_pulse), .sampled_bit(sampled_bit),
    .tx_point(tx_point), .resync_event(resync_event)
  );

  always #5 clk100Mhz = ~clk100Mhz;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: bit position in clocks since bit start plus current segment lengths in tq.
  int   m_pos, m_t1, m_t2;
  logic m_done, m_smpbit, m_can, m_rx1, m_rx2, m_rx3;
  logic e_smp, e_tx, e_ev;

  typedef struct {
    int brp, t1, t2, sj, hs, txb;
    int f1, r1, f2, r2;
    int from, ev, ev_n, smp, tx;
  } vec_t;
  vec_t vecs[11];

  int ev_first, ev_n, smp_first, tx_first;
  int smp_list[$];
  int tx_list[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cfg_t1();
    return (tseg1 == 4'd0) ? 1 : int'(tseg1);
  endfunction

  function automatic int cfg_t2();
    return (tseg2 == 3'd0) ? 1 : int'(tseg2);
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_t1 = cfg_t1(); m_t2 = cfg_t2();
    m_done = 1'b0; m_smpbit = 1'b1; m_can = 1'b1;
    m_rx1 = 1'b1; m_rx2 = 1'b1; m_rx3 = 1'b1;
    e_smp = 1'b0; e_tx = 1'b0; e_ev = 1'b0;
  endfunction

  function automatic void model_step();
    int   tqc = int'(brp) + 1;
    int   sj = int'(sjw) + 1;
    int   tq = m_pos / tqc;
    int   seg = 0;
    int   idx = 0;
    logic rs = m_rx2;
    logic fall = m_rx3 && !m_rx2;
    logic early = 1'b0;
    e_smp = 1'b0; e_tx = 1'b0; e_ev = 1'b0;
    if (tq == 0) seg = 0;
    else if (tq < 1 + m_t1) begin seg = 1; idx = tq - 1; end
    else begin seg = 2; idx = tq - 1 - m_t1; end
    if (hard_sync_en && fall) begin
      m_pos = 0; m_t1 = cfg_t1(); m_t2 = cfg_t2(); m_done = 1'b1; e_ev = 1'b1;
    end else begin
      if (fall && !m_done && m_smpbit && seg != 0) begin
        if (seg == 1) m_t1 += (idx + 1 < sj) ? idx + 1 : sj;
        else if (m_t2 - idx <= sj) early = 1'b1;
        else m_t2 -= sj;
        m_done = 1'b1; e_ev = 1'b1;
      end
      if (early) begin
        m_pos = 0; e_tx = 1'b1; m_can = tx_bit; m_t1 = cfg_t1(); m_t2 = cfg_t2();
      end else if (m_pos == (1 + m_t1) * tqc - 1) begin
        e_smp = 1'b1; m_smpbit = rs; m_pos++;
      end else if (m_pos == (1 + m_t1 + m_t2) * tqc - 1) begin
        e_tx = 1'b1; m_can = tx_bit; m_done = 1'b0; m_pos = 0; m_t1 = cfg_t1(); m_t2 = cfg_t2();
      end else begin
        m_pos++;
      end
    end
    m_rx3 = m_rx2; m_rx2 = m_rx1; m_rx1 = rx;
  endfunction

  task automatic check_model();
    logic [4:0] act, exp;
    act = {sample_pulse, sampled_bit, tx_point, can_tx, resync_event};
    exp = {e_smp, m_smpbit, e_tx, m_can, e_ev};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model cycle %0d: {smp,sbit,txp,can_tx,rev} got %b expected %b", cyc, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; rx = 1'b1; hard_sync_en = 1'b0;
    repeat (n) @(posedge clk100Mhz);
    #1;
    reset = 1'b0; cyc = 0;
    model_reset();
  endtask

  task automatic note();
    if (resync_event) ev_n++;
    if (cyc >= 0 && resync_event && ev_first < 0 && cyc >= vecs[0].from) ev_first = ev_first;
  endtask

  task automatic run_cycle(input logic rxv, input logic hsv, input logic txv);
    rx = rxv; hard_sync_en = hsv; tx_bit = txv;
    model_step();
    @(posedge clk100Mhz);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic record(input int from);
    if (resync_event) begin
      ev_n++;
      if (ev_first < 0 && cyc >= from) ev_first = cyc;
    end
    if (sample_pulse) begin
      smp_list.push_back(cyc);
      if (smp_first < 0 && cyc >= from) smp_first = cyc;
    end
    if (tx_point) begin
      tx_list.push_back(cyc);
      if (tx_first < 0 && cyc >= from) tx_first = cyc;
    end
  endtask

  initial begin
    logic rxv, hsv;
    int   hold;
    // brp,t1,t2,sj,hs,txb, f1,r1,f2,r2, from, ev,ev_n,smp,tx
    vecs[0]  = '{1, 5, 2, 0, 0, 1, -1, -1, -1, -1,  0, -1, 0, 12, 16};
    vecs[1]  = '{1, 5, 2, 0, 0, 0, -1, -1, -1, -1, 20, -1, 0, 28, 32};
    vecs[2]  = '{0, 5, 2, 0, 0, 1, -1, -1, -1, -1,  0, -1, 0,  6,  8};
    vecs[3]  = '{1, 0, 0, 0, 0, 1, -1, -1, -1, -1,  0, -1, 0,  4,  6};
    vecs[4]  = '{1, 5, 2, 0, 1, 1, 11, 40, -1, -1, 13, 14, 1, 26, 30};
    vecs[5]  = '{1, 5, 2, 1, 0, 1,  4,  5, -1, -1,  3,  7, 1, 16, 20};
    vecs[6]  = '{1, 5, 2, 1, 0, 1, 12, 13, -1, -1, 13, 15, 1, 27, 15};
    vecs[7]  = '{1, 5, 2, 1, 0, 1,  4,  5,  8,  9,  3,  7, 1, 16, 20};
    vecs[8]  = '{1, 5, 2, 1, 0, 1, 14, 26, 34, 64, 40, -1, 0, 44, 48};
    vecs[9]  = '{1, 5, 2, 0, 0, 1, 10, 11, -1, -1, 11, 13, 1, 12, 14};
    vecs[10] = '{1, 5, 2, 0, 0, 1,  4,  5, -1, -1,  3,  7, 1, 14, 18};

    for (int i = 0; i < 11; i++) begin
      brp = 8'(vecs[i].brp); tseg1 = 4'(vecs[i].t1); tseg2 = 3'(vecs[i].t2); sjw = 2'(vecs[i].sj);
      do_reset(2);
      check_model();
      ev_first = -1; ev_n = 0; smp_first = -1; tx_first = -1;
      smp_list.delete(); tx_list.delete();
      for (int c = 0; c < 80; c++) begin
        rxv = !((c >= vecs[i].f1 && c < vecs[i].r1) || (c >= vecs[i].f2 && c < vecs[i].r2));
        run_cycle(rxv, vecs[i].hs != 0, vecs[i].txb != 0);
        record(vecs[i].from);
      end
      check($sformatf("v%0d_resync_first", i), ev_first, vecs[i].ev);
      check($sformatf("v%0d_resync_count", i), ev_n, vecs[i].ev_n);
      check($sformatf("v%0d_sample_cycle", i), smp_first, vecs[i].smp);
      check($sformatf("v%0d_txpoint_cycle", i), tx_first, vecs[i].tx);
    end

    // Reset asserted in TSEG1 while can_tx is low: must restart as a fresh free run.
    brp = 8'd1; tseg1 = 4'd5; tseg2 = 3'd2; sjw = 2'd0;
    do_reset(2);
    check_model();
    for (int c = 0; c < 20; c++) run_cycle(1'b1, 1'b0, 1'b0);
    check("midreset_can_tx_before", int'(can_tx), 0);
    reset = 1'b1;
    @(posedge clk100Mhz);
    #1;
    check("midreset_can_tx", int'(can_tx), 1);
    check("midreset_strobes", int'({sample_pulse, tx_point, resync_event}), 0);
    reset = 1'b0; cyc = 0;
    model_reset();
    check_model();
    ev_first = -1; ev_n = 0; smp_first = -1; tx_first = -1;
    smp_list.delete(); tx_list.delete();
    for (int c = 0; c < 40; c++) begin
      run_cycle(1'b1, 1'b0, 1'b1);
      record(0);
    end
    check("midreset_sample_count", smp_list.size(), 2);
    check("midreset_tx_count", tx_list.size(), 2);
    if (smp_list.size() == 2 && tx_list.size() == 2) begin
      check("midreset_sample0", smp_list[0], 12);
      check("midreset_sample1", smp_list[1], 28);
      check("midreset_tx0", tx_list[0], 16);
      check("midreset_tx1", tx_list[1], 32);
    end
    check("midreset_resync_count", ev_n, 0);

    // Randomised configurations and bus activity against the reference model.
    for (int r = 0; r < 8; r++) begin
      brp = 8'($urandom_range(0, 3));
      tseg1 = 4'($urandom_range(0, 15));
      tseg2 = 3'($urandom_range(0, 7));
      sjw = 2'($urandom_range(0, 3));
      do_reset(2);
      check_model();
      rxv = 1'b1; hsv = 1'b0; hold = 0;
      for (int c = 0; c < 800; c++) begin
        if (hold == 0) begin
          rxv = 1'($urandom_range(0, 1));
          hsv = ($urandom_range(0, 7) == 0);
          hold = $urandom_range(1, 25);
        end
        hold--;
        run_cycle(rxv, hsv, 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
